// File: rtl/pcpi_mul_arbiter_if.sv
// PCPI link bundle. The requester side uses master and the coprocessor side uses slave.
// The wait flag is named pcpi_wait because "wait" is a reserved word.
interface pcpi_mul_arbiter_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/pcpi_mul_arbiter.sv
// Round-robin sharing of one PCPI multiplier between two requesters.
// Only the MUL class is forwarded. All outputs are registered.
module pcpi_mul_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    pcpi_mul_arbiter_if.slave  r0,
    pcpi_mul_arbiter_if.slave  r1,
    pcpi_mul_arbiter_if.master m
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    // ISSUE spans counter values 0..TIMEOUT, so ready lands TIMEOUT+1 cycles after m_valid rises
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT);

    function automatic logic is_mul(input logic [31:0] insn);
        return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && (insn[14] == 1'b0);
    endfunction

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  lock_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic [31:0] hold_insn_q, hold_insn_d;
    logic [31:0] hold_rs1_q, hold_rs1_d;
    logic [31:0] hold_rs2_q, hold_rs2_d;
    logic        resp_wr_q, resp_wr_d;
    logic [31:0] resp_rd_q, resp_rd_d;
    logic        m_valid_q, m_valid_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  wr_q, wr_d;
    logic [1:0]  wait_q, wait_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic [1:0]  elig_s;
    logic        gvalid_s;
    logic        busy_s;
    logic        resp_s;
    logic        unused_s;

    assign elig_s[0] = r0.pcpi_valid & is_mul(r0.pcpi_insn) & ~lock_q[0];
    assign elig_s[1] = r1.pcpi_valid & is_mul(r1.pcpi_insn) & ~lock_q[1];
    assign gvalid_s  = grant_q ? r1.pcpi_valid : r0.pcpi_valid;
    assign unused_s  = m.pcpi_wait;

    // Next-state, arbitration and registered-output decode
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        hold_insn_d  = hold_insn_q;
        hold_rs1_d   = hold_rs1_q;
        hold_rs2_d   = hold_rs2_q;
        resp_wr_d    = resp_wr_q;
        resp_rd_d    = resp_rd_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = 8'd0;
                abort_d = 1'b0;
                if (elig_s != 2'b00) begin
                    if (elig_s == 2'b11) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = elig_s[1];
                    end
                    hold_insn_d = grant_d ? r1.pcpi_insn : r0.pcpi_insn;
                    hold_rs1_d  = grant_d ? r1.pcpi_rs1  : r0.pcpi_rs1;
                    hold_rs2_d  = grant_d ? r1.pcpi_rs2  : r0.pcpi_rs2;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt_q + 8'd1;
                abort_d = abort_q | ~gvalid_s;
                if (m.pcpi_ready) begin
                    resp_wr_d = m.pcpi_wr;
                    resp_rd_d = m.pcpi_rd;
                    state_d   = abort_d ? S_IDLE : S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    resp_wr_d = 1'b0;
                    resp_rd_d = 32'd0;
                    state_d   = abort_d ? S_IDLE : S_RESP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_RESP: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_s     = ((state_d == S_ISSUE) || (state_d == S_RESP)) && !abort_d;
        resp_s     = (state_d == S_RESP);
        m_valid_d  = (state_d == S_ISSUE);
        ready_d[0] = resp_s & ~grant_d;
        ready_d[1] = resp_s & grant_d;
        wr_d       = ready_d & {2{resp_wr_d}};
        wait_d[0]  = busy_s & ~grant_d;
        wait_d[1]  = busy_s & grant_d;
        rd0_d      = ready_d[0] ? resp_rd_d : 32'd0;
        rd1_d      = ready_d[1] ? resp_rd_d : 32'd0;
    end

    // State, holding and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_q       <= 2'b00;
            cnt_q        <= 8'd0;
            abort_q      <= 1'b0;
            hold_insn_q  <= 32'd0;
            hold_rs1_q   <= 32'd0;
            hold_rs2_q   <= 32'd0;
            resp_wr_q    <= 1'b0;
            resp_rd_q    <= 32'd0;
            m_valid_q    <= 1'b0;
            ready_q      <= 2'b00;
            wr_q         <= 2'b00;
            wait_q       <= 2'b00;
            rd0_q        <= 32'd0;
            rd1_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lock_q       <= ready_q;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            hold_insn_q  <= hold_insn_d;
            hold_rs1_q   <= hold_rs1_d;
            hold_rs2_q   <= hold_rs2_d;
            resp_wr_q    <= resp_wr_d;
            resp_rd_q    <= resp_rd_d;
            m_valid_q    <= m_valid_d;
            ready_q      <= ready_d;
            wr_q         <= wr_d;
            wait_q       <= wait_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign m.pcpi_valid  = m_valid_q;
    assign m.pcpi_insn   = hold_insn_q;
    assign m.pcpi_rs1    = hold_rs1_q;
    assign m.pcpi_rs2    = hold_rs2_q;
    assign r0.pcpi_ready = ready_q[0];
    assign r0.pcpi_wr    = wr_q[0];
    assign r0.pcpi_wait  = wait_q[0];
    assign r0.pcpi_rd    = rd0_q;
    assign r1.pcpi_ready = ready_q[1];
    assign r1.pcpi_wr    = wr_q[1];
    assign r1.pcpi_wait  = wait_q[1];
    assign r1.pcpi_rd    = rd1_q;
endmodule
